parity_frame_tx: RTL and testbench
==================================

Name: parity_frame_tx

Overview:
- Byte-serialising transmit controller built around the 8-bit parity generator.
- Accepts a data word on a valid/ready handshake and computes its parity in the accept cycle.
- Shifts out a frame: start bit, data MSB-first (bit index 0 = MSB), parity bit, stop bit.
- Sits between a byte producer and a single-wire serial link; it owns the sequencing of the parity datapath.

Parameters:
- DATA_W, 8, data word width; parity is computed over all DATA_W bits.
- CLKS_PER_BIT, 4, clock cycles each frame bit is held on ser_out; legal range ≥ 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  [0:DATA_W-1]  word to send; index 0 = MSB, sent first.
- par_odd  input  1  1 = odd parity, 0 = even; sampled on accept.
- ser_out  output  1  serial line, idle high.
- busy  output  1  frame in progress.
- frame_done  output  1  one-cycle pulse in the last cycle of the stop bit.

Behaviour:
- Reset (rst_n low, async): state=IDLE, ser_out=1, busy=0, frame_done=0, in_ready=1, bit and cycle counters=0, data and parity registers=0. All outputs are registered or decoded from state only.
- States: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
- IDLE: in_ready=1, ser_out=1.
  - Accept occurs when in_valid && in_ready at a rising edge.
  - On accept: latch in_data into the shift register, latch parity = XOR(in_data) ^ par_odd (odd: total ones including parity is odd), and go to START.
- Bit timing:
  - Every frame bit is held for exactly CLKS_PER_BIT cycles by a cycle counter of width clog2(CLKS_PER_BIT)+1.
  - The counter wraps to 0 on each bit boundary.
- Per-state output:
  - START: ser_out=0.
  - DATA: ser_out = current MSB of the shift register. Shift left at each bit boundary. The bit counter runs 0..DATA_W-1, and the last data bit transitions to PARITY.
  - PARITY: ser_out = latched parity.
  - STOP: ser_out=1. frame_done=1 in its final cycle, then go to IDLE.
- Latency and frame length:
  - ser_out falls to 0 in the cycle immediately after the accept edge.
  - A frame occupies (DATA_W+3)*CLKS_PER_BIT cycles.
  - At least one IDLE cycle (ser_out=1, in_ready=1) separates consecutive frames, even with in_valid held high.
- busy = (state != IDLE). in_ready = (state == IDLE). Both are mutually exclusive at all times.
- in_data and par_odd changes after the accept edge have no effect on the frame in flight.
- in_valid while busy is ignored; the producer must hold it until accepted.
- CLKS_PER_BIT=1: each bit lasts one cycle, and frame_done coincides with the single STOP cycle.
- Reset mid-frame: outputs return to reset values immediately (ser_out=1 asynchronously). The partial frame is abandoned and not resumed.
- No other error conditions exist; the block never backpressures inside a frame.

Decomposition:
- Shared package parity_tx_pkg holds:
  - state enum: IDLE, START, DATA, PARITY, STOP.
  - constants IDLE_LEVEL=1, START_LEVEL=0, STOP_LEVEL=1.
  - function for frame length (DATA_W+3)*CLKS_PER_BIT, for use by the bench.
- One sub-module: parity_gen_w, a combinational DATA_W-bit XOR-tree parity generator with a par_odd select.
  - Instantiated once on in_data.
  - Its output is registered at accept.

Test Plan:
- Reset, then idle for 10 cycles -> ser_out=1, in_ready=1, busy=0, frame_done=0 throughout.
- Send in_data=0xA5, par_odd=1, CLKS_PER_BIT=4 -> ser_out sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1(parity),1(stop); 44 cycles total; frame_done high only in cycle 44.
- Parity table with par_odd=1: 0x00->parity 1, 0xFF->1, 0x01->0. With par_odd=0: 0x01->1, 0x00->0.
- Back-to-back with in_valid held high, words 0x3C then 0xC3 -> second accept exactly one IDLE cycle after the first frame_done; in_data changed mid-frame does not corrupt frame 1.
- Assert rst_n low during DATA bit 3 -> ser_out=1 and busy=0 asynchronously. After release, a new 0x55 frame is transmitted cleanly from START.
- CLKS_PER_BIT=1, in_data=0x80, par_odd=0 -> 11-cycle frame 0,1,0,0,0,0,0,0,0,1,1 with frame_done on cycle 11.

Source files
------------

// File: rtl/parity_tx_pkg.sv
// Shared types and constants for the parity framing transmitter.
// frame_len() gives the total frame duration in clock cycles.
package parity_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    function automatic int frame_len(input int data_w, input int clks_per_bit);
        return (data_w + 3) * clks_per_bit;
    endfunction

endpackage

// File: rtl/parity_frame_tx_gen.sv
// Combinational XOR-tree parity over a DATA_W-bit word.
// When par_odd is set, the word plus its parity bit holds an odd number of ones.
module parity_gen_w
    import parity_tx_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [0:DATA_W-1] data,
    input  logic              par_odd,
    output logic              parity
);

    assign parity = (^data) ^ par_odd;

endmodule

// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start bit, data sent MSB first, parity bit, stop bit.
// A word is accepted on a valid/ready handshake, and only while the block is idle.
module parity_frame_tx
    import parity_tx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [0:DATA_W-1] in_data,
    input  logic              par_odd,
    output logic              ser_out,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam int BIT_W = $clog2(DATA_W) + 1;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [BIT_W-1:0]   bit_cnt, bit_cnt_nxt;
    logic [0:DATA_W-1]  shreg, shreg_nxt;
    logic               par_q, par_nxt;
    logic               par_calc;
    logic               accept;
    logic               bit_end;

    parity_gen_w #(.DATA_W(DATA_W)) u_par (
        .data    (in_data),
        .par_odd (par_odd),
        .parity  (par_calc)
    );

    assign accept  = in_valid && (state == IDLE);
    assign bit_end = (cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
            shreg   <= shreg_nxt;
            par_q   <= par_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = bit_end ? '0 : cnt + CNT_W'(1);
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        par_nxt     = par_q;
        unique case (state)
            IDLE: begin
                cnt_nxt     = '0;
                bit_cnt_nxt = '0;
                if (accept) begin
                    shreg_nxt = in_data;
                    par_nxt   = par_calc;
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_end) state_nxt = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    // Index 0 is the bit on the wire; shifting left brings up the next one
                    shreg_nxt = shreg << 1;
                    if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = PARITY;
                    end else begin
                        bit_cnt_nxt = bit_cnt + BIT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_nxt = STOP;
            end
            STOP: begin
                if (bit_end) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Line level is decoded only from registers, so reset drives it idle-high at once
    always_comb begin
        ser_out = IDLE_LEVEL;
        unique case (state)
            IDLE:    ser_out = IDLE_LEVEL;
            START:   ser_out = START_LEVEL;
            DATA:    ser_out = shreg[0];
            PARITY:  ser_out = par_q;
            STOP:    ser_out = STOP_LEVEL;
            default: ser_out = IDLE_LEVEL;
        endcase
    end

    assign busy       = (state != IDLE);
    assign in_ready   = (state == IDLE);
    assign frame_done = (state == STOP) && bit_end;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Self-checking bench: table-driven and random frames checked against a frame-level model.
// Two instances cover bit times of 4 cycles and 1 cycle.
module tb_parity_frame_tx;
    import parity_tx_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    logic       v4, p4, rdy4, ser4, busy4, done4;
    logic [0:7] d4;
    logic       v1, p1, rdy1, ser1, busy1, done1;
    logic [0:7] d1;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    parity_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4), .in_data(d4),
        .par_odd(p4), .ser_out(ser4), .busy(busy4), .frame_done(done4)
    );

    parity_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
        .par_odd(p1), .ser_out(ser1), .busy(busy1), .frame_done(done1)
    );

    typedef struct {
        logic [7:0] data;
        logic       po;
        logic       exp_par;
    } par_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int cpb, input logic v, input logic [7:0] d, input logic po);
        if (cpb == 1) begin
            v1 = v; d1 = d; p1 = po;
        end else begin
            v4 = v; d4 = d; p4 = po;
        end
    endtask

    function automatic logic get_ser(input int cpb);
        return (cpb == 1) ? ser1 : ser4;
    endfunction
    function automatic logic get_rdy(input int cpb);
        return (cpb == 1) ? rdy1 : rdy4;
    endfunction
    function automatic logic get_busy(input int cpb);
        return (cpb == 1) ? busy1 : busy4;
    endfunction
    function automatic logic get_done(input int cpb);
        return (cpb == 1) ? done1 : done4;
    endfunction

    function automatic logic model_parity(input logic [7:0] d, input logic po);
        return logic'($countones(d) % 2) ^ po;
    endfunction

    // Entered at a falling edge with the DUT idle; leaves at the falling edge of the
    // idle cycle that follows the frame. keep holds in_valid high for a back-to-back frame.
    task automatic run_frame(input int cpb, input logic [7:0] d, input logic po,
                             input logic exp_par, input bit keep,
                             input logic [7:0] nd, input logic npo, input string tag);
        logic exp_bits[11];
        int   len;
        len = frame_len(8, cpb);
        exp_bits[0] = START_LEVEL;
        for (int i = 0; i < 8; i++) exp_bits[1+i] = d[7-i];
        exp_bits[9]  = exp_par;
        exp_bits[10] = STOP_LEVEL;
        drive(cpb, 1'b1, d, po);
        chk({tag, "_ready_pre"}, 32'(get_rdy(cpb)), 32'd1);
        @(posedge clk);
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            chk({tag, "_ser"},   32'(get_ser(cpb)),  32'(exp_bits[c / cpb]));
            chk({tag, "_done"},  32'(get_done(cpb)), 32'(c == len - 1));
            chk({tag, "_busy"},  32'(get_busy(cpb)), 32'd1);
            chk({tag, "_ready"}, 32'(get_rdy(cpb)),  32'd0);
            if (c == 0 && !keep) drive(cpb, 1'b0, 8'($urandom), 1'($urandom));
            if (c == len / 2)    drive(cpb, keep, nd, npo);
        end
        @(negedge clk);
        chk({tag, "_idle_ser"},   32'(get_ser(cpb)),  32'd1);
        chk({tag, "_idle_ready"}, 32'(get_rdy(cpb)),  32'd1);
        chk({tag, "_idle_busy"},  32'(get_busy(cpb)), 32'd0);
        chk({tag, "_idle_done"},  32'(get_done(cpb)), 32'd0);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        par_vec_t tbl[6];
        logic [7:0] rd;
        logic       rpo;
        int         cpb;

        tbl[0] = '{8'hA5, 1'b1, 1'b1};
        tbl[1] = '{8'h00, 1'b1, 1'b1};
        tbl[2] = '{8'hFF, 1'b1, 1'b1};
        tbl[3] = '{8'h01, 1'b1, 1'b0};
        tbl[4] = '{8'h01, 1'b0, 1'b1};
        tbl[5] = '{8'h00, 1'b0, 1'b0};

        rst_n = 1'b0;
        drive(4, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_ser4", 32'(ser4), 32'd1);
        chk("rst_ser1", 32'(ser1), 32'd1);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_ser",   32'(ser4),  32'd1);
            chk("idle_ready", 32'(rdy4),  32'd1);
            chk("idle_busy",  32'(busy4), 32'd0);
            chk("idle_done",  32'(done4), 32'd0);
            chk("idle_ser1",  32'(ser1),  32'd1);
        end

        for (int i = 0; i < 6; i++)
            run_frame(4, tbl[i].data, tbl[i].po, tbl[i].exp_par, 1'b0,
                      8'($urandom), 1'($urandom), $sformatf("tbl%0d", i));

        // Second accept must land exactly one idle cycle after the first frame_done
        run_frame(4, 8'h3C, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b1, "b2b_a");
        run_frame(4, 8'hC3, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, "b2b_b");

        // Reset during DATA bit 3 (frame bit 4, cycles 16..19), where the line is low
        drive(4, 1'b1, 8'hE0, 1'b0);
        @(posedge clk);
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (c == 0) drive(4, 1'b0, 8'h00, 1'b0);
        end
        chk("mid_ser_low", 32'(ser4), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("arst_ser",   32'(ser4),  32'd1);
        chk("arst_busy",  32'(busy4), 32'd0);
        chk("arst_ready", 32'(rdy4),  32'd1);
        chk("arst_done",  32'(done4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(4, 8'h55, 1'b0, 1'b0, 1'b0, 8'hAA, 1'b1, "post_rst");

        run_frame(1, 8'h80, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b1, "cpb1");

        for (int n = 0; n < 20; n++) begin
            cpb = (n % 2 == 1) ? 1 : 4;
            rd  = 8'($urandom);
            rpo = 1'($urandom);
            run_frame(cpb, rd, rpo, model_parity(rd, rpo), 1'b0,
                      8'($urandom), 1'($urandom), $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
